// File: rtl/udp_payload_extractor_if.sv
// rtl/udp_payload_extractor_if.sv - FIFO-side handshake and status pulses of the UDP payload extractor
interface udp_payload_extractor_if;
    logic [9:0] in_dout;
    logic       in_empty;
    logic       in_rd_en;
    logic       out_full;
    logic       out_wr_en;
    logic [9:0] out_din;
    logic       pkt_done;
    logic       pkt_drop;
    logic       pkt_err;

    modport master (
        input  in_dout, in_empty, out_full,
        output in_rd_en, out_wr_en, out_din, pkt_done, pkt_drop, pkt_err
    );

    modport slave (
        output in_dout, in_empty, out_full,
        input  in_rd_en, out_wr_en, out_din, pkt_done, pkt_drop, pkt_err
    );
endinterface

// File: rtl/udp_payload_extractor.sv
// rtl/udp_payload_extractor.sv - strips Eth/IPv4/UDP headers between two FIFOs, forwarding only the UDP payload
module udp_payload_extractor #(
    parameter int          HDR_BYTES   = 42,
    parameter logic [15:0] ETH_TYPE    = 16'h0800,
    parameter logic [7:0]  IP_PROTO    = 8'h11,
    parameter int          UDP_LEN_OFS = 38
) (
    input  logic                   clk,
    input  logic                   reset,
    udp_payload_extractor_if.master bus
);
    localparam logic [15:0] LAST_HDR   = 16'(HDR_BYTES - 1);
    localparam logic [15:0] OFS_ETH_HI = 16'd12;
    localparam logic [15:0] OFS_ETH_LO = 16'd13;
    localparam logic [15:0] OFS_PROTO  = 16'd23;
    localparam logic [15:0] OFS_LEN_HI = 16'(UDP_LEN_OFS);
    localparam logic [15:0] OFS_LEN_LO = 16'(UDP_LEN_OFS + 1);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DRAIN} state_t;

    state_t      r_state,     w_state_nxt;
    logic        r_rd_valid;
    logic        r_pending,   w_pending_nxt;
    logic [9:0]  r_pend_word, w_pend_word_nxt;
    logic [15:0] r_cnt,       w_cnt_nxt;
    logic [15:0] r_pcnt,      w_pcnt_nxt;
    logic [15:0] r_plen,      w_plen_nxt;
    logic [15:0] r_eth_type,  w_eth_type_nxt;
    logic [7:0]  r_proto,     w_proto_nxt;
    logic [15:0] r_udp_len,   w_udp_len_nxt;

    logic        w_fwd;
    logic [9:0]  w_fwd_word;
    logic        w_done;
    logic        w_drop;
    logic        w_err;
    logic        w_rd_en;
    logic        w_wr_en;
    logic        w_sof;
    logic        w_eof;
    logic [7:0]  w_byte;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_sof  = bus.in_dout[9];
    assign w_eof  = bus.in_dout[8];
    assign w_byte = bus.in_dout[7:0];

    // A payload byte arriving into a full downstream FIFO parks in r_pend_word, so stop popping
    assign w_rd_en = reset && !bus.in_empty && !r_pending &&
                     !(r_rd_valid && (r_state == S_PAYLOAD) && bus.out_full);
    assign w_wr_en = !bus.out_full && (r_pending || w_fwd);

    assign bus.in_rd_en  = w_rd_en;
    assign bus.out_wr_en = w_wr_en;
    assign bus.out_din   = !w_wr_en ? 10'd0 : (r_pending ? r_pend_word : w_fwd_word);
    assign bus.pkt_done  = w_done;
    assign bus.pkt_drop  = w_drop;
    assign bus.pkt_err   = w_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending;
        w_pend_word_nxt = r_pend_word;
        w_cnt_nxt       = r_cnt;
        w_pcnt_nxt      = r_pcnt;
        w_plen_nxt      = r_plen;
        w_eth_type_nxt  = r_eth_type;
        w_proto_nxt     = r_proto;
        w_udp_len_nxt   = r_udp_len;
        w_fwd           = 1'b0;
        w_fwd_word      = 10'd0;
        w_done          = 1'b0;
        w_drop          = 1'b0;
        w_err           = 1'b0;

        if (r_pending && !bus.out_full) begin
            w_pending_nxt = 1'b0;
        end

        if (r_rd_valid) begin
            if ((r_state != S_IDLE) && w_sof) begin
                // An unexpected sof aborts the frame and is itself header byte 0 of the next one
                w_err       = 1'b1;
                w_cnt_nxt   = 16'd1;
                w_state_nxt = w_eof ? S_IDLE : S_HEADER;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_sof && w_eof) begin
                            w_err = 1'b1;
                        end else if (w_sof) begin
                            w_state_nxt = S_HEADER;
                            w_cnt_nxt   = 16'd1;
                        end
                    end
                    S_HEADER: begin
                        if (r_cnt == OFS_ETH_HI) w_eth_type_nxt[15:8] = w_byte;
                        if (r_cnt == OFS_ETH_LO) w_eth_type_nxt[7:0]  = w_byte;
                        if (r_cnt == OFS_PROTO)  w_proto_nxt          = w_byte;
                        if (r_cnt == OFS_LEN_HI) w_udp_len_nxt[15:8]  = w_byte;
                        if (r_cnt == OFS_LEN_LO) w_udp_len_nxt[7:0]   = w_byte;
                        if (r_cnt == LAST_HDR) begin
                            if ((r_eth_type != ETH_TYPE) || (r_proto != IP_PROTO)) begin
                                w_drop      = 1'b1;
                                w_state_nxt = w_eof ? S_IDLE : S_DRAIN;
                            end else if (r_udp_len < 16'd8) begin
                                w_err       = 1'b1;
                                w_state_nxt = w_eof ? S_IDLE : S_DRAIN;
                            end else if (r_udp_len == 16'd8) begin
                                w_done      = 1'b1;
                                w_state_nxt = w_eof ? S_IDLE : S_DRAIN;
                            end else if (w_eof) begin
                                w_err       = 1'b1;
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_state_nxt = S_PAYLOAD;
                                w_pcnt_nxt  = 16'd0;
                                w_plen_nxt  = r_udp_len - 16'd8;
                            end
                        end else if (w_eof) begin
                            w_err       = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt = sat_inc(r_cnt);
                        end
                    end
                    S_PAYLOAD: begin
                        w_fwd      = 1'b1;
                        w_fwd_word = {(r_pcnt == 16'd0), (r_pcnt == r_plen - 16'd1), w_byte};
                        w_pcnt_nxt = sat_inc(r_pcnt);
                        if (r_pcnt == r_plen - 16'd1) begin
                            w_done      = 1'b1;
                            w_state_nxt = w_eof ? S_IDLE : S_DRAIN;
                        end else if (w_eof) begin
                            w_err       = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_DRAIN: begin
                        if (w_eof) w_state_nxt = S_IDLE;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end

            if (w_fwd && bus.out_full) begin
                w_pending_nxt   = 1'b1;
                w_pend_word_nxt = w_fwd_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rd_valid  <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_word <= 10'd0;
            r_cnt       <= 16'd0;
            r_pcnt      <= 16'd0;
            r_plen      <= 16'd0;
            r_eth_type  <= 16'd0;
            r_proto     <= 8'd0;
            r_udp_len   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_valid  <= w_rd_en;
            r_pending   <= w_pending_nxt;
            r_pend_word <= w_pend_word_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_plen      <= w_plen_nxt;
            r_eth_type  <= w_eth_type_nxt;
            r_proto     <= w_proto_nxt;
            r_udp_len   <= w_udp_len_nxt;
        end
    end
endmodule

// File: doc/udp_payload_extractor.md
Name: udp_payload_extractor

Overview:
Single-clock parser between two FIFO stages. Pops 10-bit framed byte words from the upstream ingress FIFO, checks the Ethernet/IPv4/UDP header, strips it, and pushes only the UDP payload to the downstream FIFO with re-generated sof/eof flags. Non-UDP frames are dropped. Malformed frames raise an error pulse.

Parameters:
HDR_BYTES, 42, header length in bytes (Eth 14 + IPv4 20 + UDP 8); IPv4 without options only
ETH_TYPE, 16'h0800, required EtherType at byte offsets 12-13 (big-endian)
IP_PROTO, 8'h11, required IPv4 protocol at byte offset 23
UDP_LEN_OFS, 38, offset of the UDP length MSB; LSB is at +1

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active low (0 = reset)
in_dout  in  10  upstream FIFO data: [9]=sof, [8]=eof, [7:0]=byte
in_empty  in  1  upstream FIFO empty
in_rd_en  out  1  upstream FIFO pop
out_full  in  1  downstream FIFO full
out_wr_en  out  1  downstream FIFO push
out_din  out  10  downstream word, same format as in_dout
pkt_done  out  1  1-cycle pulse: payload fully forwarded
pkt_drop  out  1  1-cycle pulse: valid frame, not ETH_TYPE/IP_PROTO
pkt_err  out  1  1-cycle pulse: truncated frame, udp_len<8, or unexpected sof

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. byte counter, pending flag and captured fields cleared. in_rd_en=0, out_wr_en=0, out_din=0, all pulses 0.
- Upstream read latency: in_dout is valid the cycle after a cycle with in_rd_en=1 && in_empty=0. Track this with an internal rd_valid flop.
- in_rd_en = !in_empty && !pending && !(rd_valid && state==PAYLOAD && out_full). Sustained rate is 1 byte/clk when both FIFOs allow it.
- pending: a payload byte arrives while out_full=1. Hold it in a 10-bit register and do not pop until it is written. Write it the first cycle with out_full=0.
- out_wr_en is asserted only when out_full=0. A byte is never written twice and never lost.
- IDLE: discard words until one has sof=1. That byte is header byte 0. Go to HEADER with cnt=1.
- HEADER: capture bytes 12,13 (EtherType), 23 (proto), UDP_LEN_OFS and UDP_LEN_OFS+1 (udp_len). On byte HDR_BYTES-1:
  - EtherType or protocol mismatch: pkt_drop, go to DRAIN.
  - udp_len<8: pkt_err, go to DRAIN.
  - udp_len==8: pkt_done. Go to IDLE if this byte had eof, else DRAIN.
  - Otherwise: plen=udp_len-8 (16-bit), go to PAYLOAD with pcnt=0.
- PAYLOAD: forward each byte.
  - sof=1 on pcnt==0, else 0.
  - eof=1 on pcnt==plen-1, else 0.
  - On the last byte: pkt_done. Go to IDLE if the input had eof, else DRAIN (Ethernet padding).
- DRAIN: discard bytes until eof=1, then go to IDLE.
- Input eof before the expected end (in HEADER, or PAYLOAD with pcnt<plen-1): pkt_err, go to IDLE. No eof word is emitted; the downstream stage resyncs on the next sof.
- sof=1 in HEADER/PAYLOAD/DRAIN: pkt_err. Abort the current frame. Treat that byte as header byte 0 of a new frame (cnt=1, state=HEADER).
- A byte with both sof and eof in IDLE: pkt_err, stay in IDLE.
- Counters are 16-bit and saturate. udp_len=65535 must not wrap plen.
- Reset mid-frame: everything returns to IDLE immediately. The partial frame already in the downstream FIFO is not recalled.

Test Plan:
1. UDP frame, 42-byte header, udp_len=16'h000C, 4 payload bytes A1..A4, eof on A4 -> 4 pushes: 0x2A1, 0x0A2, 0x0A3, 0x1A4. pkt_done once. No pops after the eof word.
2. Same frame with out_full held 1 for 5 cycles starting at payload byte 2 -> pending holds 0x0A2. in_rd_en=0 during the stall. Output sequence identical to test 1, with no duplicates.
3. EtherType 16'h86DD -> pkt_drop at byte 41. Zero pushes. Words discarded until eof. Next valid frame is parsed normally.
4. udp_len=16'h000A (2 payload bytes) with 4 padding bytes before eof -> pushes 0x2xx, 0x1xx. pkt_done. Padding discarded.
5. eof at header byte 30, and separately sof arriving at payload byte 3 -> pkt_err pulse each time. The second case restarts header parsing and the new frame is forwarded correctly.
6. Assert reset=0 asynchronously mid-payload -> outputs 0 within the same cycle. After release, the block waits in IDLE for sof.
